// File: rtl/instr_mem_loader.sv
// Program-load front end: packs UART bytes into big-endian instruction
// words and writes them to instruction memory until HALT or memory full.
module instr_mem_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int SIZEOP     = 6,
  parameter logic [SIZEOP-1:0] HALT_OP = '1
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [BYTE_WIDTH-1:0] i_rx_data,
  input  logic                  i_rx_valid,
  output logic                  o_we,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_overflow,
  output logic [ADDR_WIDTH:0]   o_count
);

  localparam int NBYTES = DATA_WIDTH / BYTE_WIDTH;
  localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CW-1:0] LAST_BYTE = CW'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, next_state;

  logic [DATA_WIDTH-1:0] word_buf;
  logic [DATA_WIDTH-1:0] word_next;
  logic [ADDR_WIDTH-1:0] addr;
  logic [CW-1:0]         byte_cnt;
  logic                  start_ok;
  logic                  byte_ok;
  logic                  word_done;
  logic                  is_halt;
  logic                  at_last;

  assign start_ok  = i_start && (state != RECV);
  assign byte_ok   = i_rx_valid && (state == RECV);
  assign word_next = {word_buf[DATA_WIDTH-BYTE_WIDTH-1:0], i_rx_data};
  assign word_done = byte_ok && (byte_cnt == LAST_BYTE);
  assign is_halt   = word_next[DATA_WIDTH-1 -: SIZEOP] == HALT_OP;
  assign at_last   = addr == '1;

  always_ff @(posedge i_clock) begin
    if (i_reset) state <= IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: if (i_start) next_state = RECV;
      RECV: if (word_done && (is_halt || at_last))
              next_state = DONE;
      DONE: if (i_start) next_state = RECV;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    o_busy = (state == RECV);
    o_done = (state == DONE);
  end

  // The terminal word is written on the same edge that enters DONE.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_we       <= 1'b0;
      o_addr     <= '0;
      o_data     <= '0;
      o_overflow <= 1'b0;
      o_count    <= '0;
      word_buf   <= '0;
      addr       <= '0;
      byte_cnt   <= '0;
    end else begin
      o_we <= 1'b0;
      if (start_ok) begin
        addr       <= '0;
        byte_cnt   <= '0;
        word_buf   <= '0;
        o_count    <= '0;
        o_overflow <= 1'b0;
      end else if (byte_ok) begin
        word_buf <= word_next;
        byte_cnt <= byte_cnt + CW'(1);
        if (word_done) begin
          o_we       <= 1'b1;
          o_addr     <= addr;
          o_data     <= word_next;
          addr       <= addr + ADDR_WIDTH'(1);
          o_count    <= o_count + (ADDR_WIDTH+1)'(1);
          o_overflow <= at_last && !is_halt;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Bench for instr_mem_loader: a full-depth and a 4-word instance share
// one randomized byte stream and are checked against a per-cycle model.
module tb_instr_mem_loader;

  logic       clk;
  logic       i_reset;
  logic       i_start;
  logic [7:0] i_rx_data;
  logic       i_rx_valid;

  logic        we0, busy0, done0, ovf0;
  logic [7:0]  addr0;
  logic [31:0] data0;
  logic [8:0]  cnt0;

  logic        we1, busy1, done1, ovf1;
  logic [1:0]  addr1;
  logic [31:0] data1;
  logic [2:0]  cnt1;

  int total = 0;
  int bad   = 0;

  int          depth [2] = '{256, 4};
  int          m_st  [2];
  int          m_cnt [2];
  int          m_nb  [2];
  int          m_nadr[2];
  logic        m_ovf [2];
  logic        m_we  [2];
  int          m_oadr[2];
  logic [31:0] m_odat[2];
  logic [31:0] m_acc [2];

  instr_mem_loader #(.ADDR_WIDTH(8)) u_full (
    .i_clock(clk), .i_reset(i_reset), .i_start(i_start),
    .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
    .o_we(we0), .o_addr(addr0), .o_data(data0), .o_busy(busy0),
    .o_done(done0), .o_overflow(ovf0), .o_count(cnt0)
  );

  instr_mem_loader #(.ADDR_WIDTH(2)) u_small (
    .i_clock(clk), .i_reset(i_reset), .i_start(i_start),
    .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
    .o_we(we1), .o_addr(addr1), .o_data(data1), .o_busy(busy1),
    .o_done(done1), .o_overflow(ovf1), .o_count(cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // States: 0 idle, 1 loading, 2 done.
  task automatic model_step(input int k, input logic rst, input logic st,
                            input logic v, input logic [7:0] b);
    if (rst) begin
      m_st[k] = 0; m_cnt[k] = 0; m_nb[k] = 0; m_nadr[k] = 0;
      m_ovf[k] = 0; m_we[k] = 0; m_oadr[k] = 0;
      m_odat[k] = '0; m_acc[k] = '0;
    end else begin
      m_we[k] = 0;
      if (m_st[k] != 1 && st) begin
        m_st[k] = 1; m_nadr[k] = 0; m_cnt[k] = 0;
        m_ovf[k] = 0; m_nb[k] = 0;
      end else if (m_st[k] == 1 && v) begin
        m_acc[k] = {m_acc[k][23:0], b};
        m_nb[k]++;
        if (m_nb[k] == 4) begin
          m_nb[k] = 0;
          m_we[k] = 1;
          m_oadr[k] = m_nadr[k];
          m_odat[k] = m_acc[k];
          m_cnt[k]++;
          if (m_acc[k][31:26] == 6'h3f) m_st[k] = 2;
          else if (m_nadr[k] == depth[k] - 1) begin
            m_st[k] = 2;
            m_ovf[k] = 1;
          end
          m_nadr[k]++;
        end
      end
    end
  endtask

  task automatic check_all();
    chk("we_full",   64'(we0),   64'(m_we[0]));
    chk("addr_full", 64'(addr0), 64'(m_oadr[0] & 255));
    chk("data_full", 64'(data0), 64'(m_odat[0]));
    chk("busy_full", 64'(busy0), 64'(m_st[0] == 1));
    chk("done_full", 64'(done0), 64'(m_st[0] == 2));
    chk("ovf_full",  64'(ovf0),  64'(m_ovf[0]));
    chk("cnt_full",  64'(cnt0),  64'(m_cnt[0]));
    chk("we_small",   64'(we1),   64'(m_we[1]));
    chk("addr_small", 64'(addr1), 64'(m_oadr[1] & 3));
    chk("data_small", 64'(data1), 64'(m_odat[1]));
    chk("busy_small", 64'(busy1), 64'(m_st[1] == 1));
    chk("done_small", 64'(done1), 64'(m_st[1] == 2));
    chk("ovf_small",  64'(ovf1),  64'(m_ovf[1]));
    chk("cnt_small",  64'(cnt1),  64'(m_cnt[1]));
  endtask

  task automatic cycle(input logic rst, input logic st,
                       input logic v, input logic [7:0] b);
    i_reset = rst; i_start = st; i_rx_valid = v; i_rx_data = b;
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_step(k, rst, st, v, b);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      cycle(1'b0, 1'b0, 1'b0, 8'($urandom));
  endtask

  task automatic send_byte(input logic [7:0] b);
    idle($urandom_range(0, 2));
    cycle(1'b0, 1'b0, 1'b1, b);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8]);
  endtask

  function automatic logic [31:0] rnd_word();
    logic [31:0] w;
    w = $urandom;
    w[31:26] = 6'($urandom_range(0, 62));
    return w;
  endfunction

  function automatic logic [31:0] halt_word();
    logic [31:0] w;
    w = $urandom;
    w[31:26] = 6'h3f;
    return w;
  endfunction

  initial begin
    i_reset = 1'b1; i_start = 1'b0; i_rx_valid = 1'b0; i_rx_data = 8'h00;

    // Reset, then stray bytes while idle.
    cycle(1'b1, 1'b0, 1'b0, 8'h00);
    cycle(1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1, 8'($urandom));

    // Two-word load ending in HALT; start+valid drops the byte.
    cycle(1'b0, 1'b1, 1'b1, 8'h77);
    send_word(32'h2001_0005);
    send_word(32'hFC00_0000);
    idle(2);
    chk("t2_count", 64'(cnt0), 64'd2);
    chk("t2_done",  64'(done0), 64'd1);
    chk("t2_ovf",   64'(ovf0), 64'd0);

    // Reset mid-word, then a fresh load.
    cycle(1'b0, 1'b1, 1'b0, 8'h00);
    send_byte(8'h20);
    send_byte(8'h01);
    cycle(1'b1, 1'b0, 1'b0, 8'h00);
    idle(2);
    chk("t3_count", 64'(cnt0), 64'd0);
    chk("t3_busy",  64'(busy0), 64'd0);
    cycle(1'b0, 1'b1, 1'b0, 8'h00);
    send_word(rnd_word());
    chk("t3_addr0", 64'(addr0), 64'd0);
    send_word(halt_word());
    idle(1);

    // Fill the 4-word instance; a 5th word must not be written there.
    cycle(1'b0, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) send_word(rnd_word());
    idle(1);
    chk("t4_done", 64'(done1), 64'd1);
    chk("t4_ovf",  64'(ovf1), 64'd1);
    chk("t4_cnt",  64'(cnt1), 64'd4);
    send_word(rnd_word());
    chk("t4_cnt5", 64'(cnt1), 64'd4);
    send_word(halt_word());
    idle(1);

    // Restart from DONE with a single word.
    cycle(1'b0, 1'b1, 1'b0, 8'h00);
    send_word(rnd_word());
    idle(1);
    chk("t6_ovf",  64'(ovf1), 64'd0);
    chk("t6_done", 64'(done1), 64'd0);
    chk("t6_cnt",  64'(cnt1), 64'd1);
    send_word(halt_word());
    idle(1);

    // Back-to-back bytes with a start pulse mid-load.
    cycle(1'b0, 1'b1, 1'b0, 8'h00);
    begin
      logic [31:0] w [3];
      w[0] = rnd_word(); w[1] = rnd_word(); w[2] = halt_word();
      for (int i = 0; i < 12; i++)
        cycle(1'b0, i == 6, 1'b1, w[i/4][8*(3 - i%4) +: 8]);
    end
    idle(3);
    chk("t5_cnt",  64'(cnt0), 64'd3);
    chk("t5_done", 64'(done0), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
